fifo_wr_arbiter: RTL and testbench

Single-clock round-robin arbiter that shares the write port of the team's 8-bit FIFO between several requesters. It sits in the FIFO write-clock domain and drives the FIFO's `write_enable`/`write_data` directly. It grants one requester at a time for a bounded burst and stalls on `fifo_full` without losing the grant. It also keeps a running count of accepted words.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Brief    : Shared constants and state encoding for the FIFO write arbiter.
// Revision : 1.0
// ============================================================================
package fifo_arb_pkg;

    localparam logic [0:0] c_state_idle  = 1'b0;
    localparam logic [0:0] c_state_grant = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = c_state_idle,
        ST_GRANT = c_state_grant
    } arb_state_t;

    localparam int c_default_max_burst = 4;
    localparam int c_word_count_w      = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker (rotate, priority-encode, un-rotate).
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               found,
    output logic [PTR_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]     w_rot_idx;
    logic [PTR_W:0]       w_sum;

    // Rotating right by rr_ptr puts the highest-priority requester at bit 0.
    assign w_req_dbl = {req, req};
    assign w_rot     = w_req_dbl[rr_ptr +: NUM_REQ];

    always_comb begin
        w_rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_rot_idx = PTR_W'(i);
            end
        end
    end

    assign w_sum = {1'b0, w_rot_idx} + {1'b0, rr_ptr};
    assign idx   = (w_sum >= (PTR_W+1)'(NUM_REQ)) ?
                   PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ)) : w_sum[PTR_W-1:0];
    assign found = |req;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter driving the shared FIFO write port.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = c_default_max_burst
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          write_enable,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [c_word_count_w-1:0]     word_count
);

    localparam int c_ptr_w = $clog2(NUM_REQ);

    arb_state_t                r_state, w_state_nxt;
    logic [c_ptr_w-1:0]        r_owner, w_owner_nxt;
    logic [c_ptr_w-1:0]        r_rr_ptr, w_rr_ptr_nxt;
    logic [3:0]                r_burst_cnt, w_burst_cnt_nxt;
    logic [c_word_count_w-1:0] r_word_count, w_word_count_nxt;

    logic                  w_pick_found;
    logic [c_ptr_w-1:0]    w_pick_idx;
    logic                  w_grant;
    logic                  w_owner_req;
    logic [DATA_WIDTH-1:0] w_owner_data;
    logic                  w_write;
    logic                  w_last;
    logic                  w_release;
    logic [c_ptr_w-1:0]    w_next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_pick_found),
        .idx    (w_pick_idx)
    );

    assign w_grant      = (r_state == ST_GRANT);
    assign w_owner_req  = req[r_owner];
    assign w_owner_data = req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
    // fifo_full arrives registered from the FIFO, so gating it here is one level.
    assign w_write      = w_grant & w_owner_req & ~fifo_full;
    assign w_last       = (r_burst_cnt == 4'(MAX_BURST - 1));
    assign w_release    = w_grant & (~w_owner_req | (w_write & w_last));
    assign w_next_ptr   = (r_owner == c_ptr_w'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_burst_cnt_nxt  = r_burst_cnt;
        w_word_count_nxt = r_word_count;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_owner_nxt     = w_pick_idx;
                    w_burst_cnt_nxt = '0;
                    w_state_nxt     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_write) begin
                    w_burst_cnt_nxt  = r_burst_cnt + 4'd1;
                    w_word_count_nxt = r_word_count + 1'b1;
                end
                if (w_release) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = w_next_ptr;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_burst_cnt  <= '0;
            r_word_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_word_count <= w_word_count_nxt;
        end
    end

    assign write_enable = w_write;
    assign ack          = {{(NUM_REQ-1){1'b0}}, w_write} << r_owner;
    assign write_data   = w_grant ? w_owner_data : '0;
    assign grant_valid  = w_grant;
    assign grant_id     = r_owner;
    assign word_count   = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed scoreboard bench for fifo_wr_arbiter.
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        fifo_full;
    logic [3:0]  ack;
    logic        write_enable;
    logic [7:0]  write_data;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [15:0] word_count;

    logic        w_reset;
    logic [1:0]  w_req;
    logic [15:0] w_req_data;
    logic [1:0]  w_ack;
    logic        w_write_enable;
    logic [7:0]  w_write_data;
    logic        w_grant_valid;
    logic [0:0]  w_grant_id;
    logic [15:0] w_word_count;

    int total;
    int bad;
    logic mon_en;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;
    exp_t sb_q[$];

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .fifo_full    (fifo_full),
        .ack          (ack),
        .write_enable (write_enable),
        .write_data   (write_data),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .word_count   (word_count)
    );

    fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(16)) dut_wrap (
        .clk          (clk),
        .reset        (w_reset),
        .req          (w_req),
        .req_data     (w_req_data),
        .fifo_full    (1'b0),
        .ack          (w_ack),
        .write_enable (w_write_enable),
        .write_data   (w_write_data),
        .grant_valid  (w_grant_valid),
        .grant_id     (w_grant_id),
        .word_count   (w_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] id, input int n);
        exp_t e;
        e.data = d;
        e.id   = id;
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    // Scoreboard: every FIFO write must match the next expected word.
    always @(negedge clk) begin
        exp_t e;
        if (write_enable === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {24'd0, write_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("wr_data", write_data, e.data);
                chk("wr_id", grant_id, e.id);
                chk("wr_ack", ack, 4'b0001 << e.id);
            end
        end else if (mon_en) begin
            chk("idle_ack", ack, 0);
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        mon_en     = 1'b0;
        reset      = 1'b1;
        w_reset    = 1'b1;
        req        = 4'b1111;
        req_data   = {8'h40, 8'h30, 8'h20, 8'h10};
        fifo_full  = 1'b0;
        w_req      = 2'b00;
        w_req_data = 16'h0201;

        // Reset held for two cycles with every requester active
        for (int i = 0; i < 2; i++) begin
            step();
            mon_en = 1'b1;
            #3;
            chk("rst_we", write_enable, 0);
            chk("rst_ack", ack, 0);
            chk("rst_wdata", write_data, 0);
            chk("rst_gvalid", grant_valid, 0);
            chk("rst_gid", grant_id, 0);
            chk("rst_wcount", word_count, 0);
        end

        // Round robin: full bursts in order 0,1,2,3,0
        for (int b = 0; b < 5; b++) push(8'h10 * (b % 4 + 1), 2'(b % 4), 4);
        reset = 1'b0;
        for (int b = 0; b < 5; b++) begin
            step(); #3;
            chk("rr_gvalid", grant_valid, 1);
            chk("rr_gid", grant_id, b % 4);
            repeat (3) step();
            step(); #3;
            chk("rr_gap", grant_valid, 0);
        end
        req = 4'b0000;
        chk("rr_wcount", word_count, 20);

        // Single requester long burst after a fresh reset
        reset = 1'b1;
        step(); #3;
        chk("lb_rst_wcount", word_count, 0);
        reset = 1'b0;
        req = 4'b0100;
        req_data[23:16] = 8'hCA;
        push(8'hCA, 2'd2, 8);
        step(); #3;
        chk("lb_gid1", grant_id, 2);
        repeat (3) step();
        step(); #3;
        chk("lb_gap", grant_valid, 0);
        step(); #3;
        chk("lb_gid2", grant_id, 2);
        chk("lb_gvalid2", grant_valid, 1);
        repeat (3) step();
        step(); #3;
        chk("lb_wcount", word_count, 8);
        chk("lb_release", grant_valid, 0);
        req = 4'b0000;

        // FIFO full stall after two words (rr_ptr is 3, so search wraps to 1)
        req = 4'b0010;
        req_data[15:8] = 8'h5A;
        push(8'h5A, 2'd1, 4);
        step(); #3;
        chk("st_gid", grant_id, 1);
        step();
        step();
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("st_we", write_enable, 0);
            chk("st_ack", ack, 0);
            chk("st_gid_hold", grant_id, 1);
            chk("st_gvalid", grant_valid, 1);
            chk("st_wcount", word_count, 10);
            if (k < 4) step();
        end
        step();
        fifo_full = 1'b0;
        step();
        step(); #3;
        chk("st_release", grant_valid, 0);
        chk("st_wcount_end", word_count, 12);
        req = 4'b0000;

        // Early release: owner 3 drops after one word, rotation wraps to 0
        req = 4'b1001;
        req_data[31:24] = 8'hAA;
        req_data[7:0]   = 8'h77;
        push(8'hAA, 2'd3, 1);
        push(8'h77, 2'd0, 4);
        step(); #3;
        chk("er_gid", grant_id, 3);
        step();
        req = 4'b0001;
        #3;
        chk("er_drop_we", write_enable, 0);
        chk("er_drop_gvalid", grant_valid, 1);
        step(); #3;
        chk("er_idle", grant_valid, 0);
        step(); #3;
        chk("er_next_gid", grant_id, 0);
        chk("er_next_gvalid", grant_valid, 1);
        repeat (3) step();
        step(); #3;
        chk("er_wcount", word_count, 17);
        req = 4'b0000;

        // Reset asserted during a grant
        req = 4'b0010;
        req_data[15:8] = 8'h66;
        push(8'h66, 2'd1, 1);
        step(); #3;
        chk("mr_gid", grant_id, 1);
        chk("mr_we", write_enable, 1);
        reset = 1'b1;
        step(); #3;
        chk("mr_we_after", write_enable, 0);
        chk("mr_gvalid", grant_valid, 0);
        chk("mr_wcount", word_count, 0);
        step();
        reset = 1'b0;
        req = 4'b0000;
        step(); #3;
        chk("mr_idle", grant_valid, 0);
        chk("sb_empty", sb_q.size(), 0);

        // Word counter wrap on a 16-word-burst instance
        w_req = 2'b01;
        step();
        w_reset = 1'b0;
        repeat (69631) step();
        #3;
        chk("wrap_ffff", w_word_count, 16'hFFFF);
        step(); #3;
        chk("wrap_zero", w_word_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
